// File: rtl/cpu_bus_sched_pkg.sv
// Shared types for the CPU bus sequencer: access tags for the RAM pipeline
// and the bus-hold FSM states.
package cpu_bus_sched_pkg;

  localparam int CE_DIV_MIN = 4;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_VID  = 2'd2
  } acc_tag_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } hold_state_e;

  // One RAM pipeline slot: who owns it and whether it was a CPU write.
  typedef struct packed {
    acc_tag_e tag;
    logic     wr;
  } acc_t;

  localparam acc_t ACC_NONE = '{tag: TAG_NONE, wr: 1'b0};

endpackage

// File: rtl/cpu_irq_latch.sv
// Vertical-blank IRQ: rising-edge detect on vblank sets irq_n low,
// irq_clr releases it; a simultaneous set beats the clear.
module cpu_irq_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic vblank,
  input  logic irq_clr,
  output logic irq_n
);

  logic vblank_d;
  logic vblank_rise;

  assign vblank_rise = vblank & ~vblank_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblank_d <= 1'b0;
      irq_n    <= 1'b1;
    end else begin
      vblank_d <= vblank;
      if (vblank_rise)  irq_n <= 1'b0;
      else if (irq_clr) irq_n <= 1'b1;
    end
  end

endmodule

// File: rtl/cpu_bus_sched.sv
// CPU clock-enable sequencer, shared RAM arbiter (CPU slot vs video fetch),
// vblank IRQ and external bus-hold handshake.
module cpu_bus_sched
  import cpu_bus_sched_pkg::*;
#(
  parameter int CE_DIV = 4,
  parameter int AW     = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          cpu_en,
  output logic          cpu_rdy,
  input  logic [15:0]   cpu_ab,
  input  logic          cpu_we_n,
  input  logic          cpu_sel,
  output logic [7:0]    cpu_di,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  input  logic [7:0]    ram_dout,
  input  logic          vblank,
  input  logic          irq_clr,
  output logic          irq_n,
  input  logic          hold_req,
  output logic          hold_ack
);

  localparam int            CW       = $clog2(CE_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CE_DIV - 1);

  logic [CW-1:0] cnt;
  hold_state_e   state, state_nxt;
  acc_t          pipe_s1, pipe_s2;
  logic          vid_pend;
  logic          cpu_grant, vid_grant;
  logic          unused_ab;

  assign unused_ab = ^cpu_ab[15:AW];

  // cnt==0 is the first cycle after the wrapper latched a fresh address.
  assign cpu_grant = (cnt == '0) && cpu_sel && cpu_rdy;
  assign vid_grant = !cpu_grant && vid_req && !vid_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      cpu_en   <= 1'b0;
      ram_addr <= '0;
      ram_we   <= 1'b0;
      pipe_s1  <= ACC_NONE;
      pipe_s2  <= ACC_NONE;
      vid_pend <= 1'b0;
      vid_ack  <= 1'b0;
      cpu_di   <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments here so every register sees pre-edge values.
      cnt     <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      cpu_en  <= (cnt == CNT_LAST - 1'b1);
      ram_we  <= 1'b0;
      pipe_s1 <= ACC_NONE;
      if (cpu_grant) begin
        ram_addr <= cpu_ab[AW-1:0];
        ram_we   <= ~cpu_we_n;
        pipe_s1  <= '{tag: TAG_CPU, wr: ~cpu_we_n};
      end else if (vid_grant) begin
        ram_addr <= vid_addr;
        pipe_s1  <= '{tag: TAG_VID, wr: 1'b0};
      end
      pipe_s2 <= pipe_s1;
      // ram_dout belongs to whichever tag sits in pipe_s2 this cycle.
      vid_ack <= (pipe_s1.tag == TAG_VID);
      if (pipe_s2.tag == TAG_CPU && !pipe_s2.wr) cpu_di <= ram_dout;
      if (vid_grant)                    vid_pend <= 1'b1;
      else if (pipe_s2.tag == TAG_VID)  vid_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      ST_RUN:  if (cpu_en && hold_req) state_nxt = ST_HOLD;
      ST_HOLD: if (!hold_req)          state_nxt = ST_RUN;
      default:                         state_nxt = ST_RUN;
    endcase
  end

  assign cpu_rdy  = (state == ST_RUN);
  assign hold_ack = (state == ST_HOLD);

  cpu_irq_latch u_irq (
    .clk     (clk),
    .rst_n   (rst_n),
    .vblank  (vblank),
    .irq_clr (irq_clr),
    .irq_n   (irq_n)
  );

endmodule

// File: doc/cpu_bus_sched.md
Name: cpu_bus_sched

Overview:
- Sequencer and arbiter around the 6502 CPU wrapper.
- Generates the CPU clock-enable strobe and the RDY line.
- Time-shares one synchronous video/work RAM port between the CPU and the video fetch engine.
- Raises the vblank IRQ and grants full-bus hold to an external master (e.g. a test/DMA loader).

Parameters:
- CE_DIV, 4, clk cycles per CPU enable; legal minimum 4.
- AW, 11, shared RAM address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_en  out  1  one-cycle enable strobe to the CPU wrapper
- cpu_rdy  out  1  CPU ready; low = CPU frozen
- cpu_ab  in  16  registered CPU address from the wrapper
- cpu_we_n  in  1  registered CPU write strobe, active low
- cpu_sel  in  1  address decode: cpu_ab hits the shared RAM
- cpu_di  out  8  latched RAM read data for the CPU data-in mux
- vid_req  in  1  video fetch request; level, held until vid_ack
- vid_addr  in  AW  video fetch address
- vid_ack  out  1  one-cycle pulse; ram_dout is valid for video this cycle
- ram_addr  out  AW  RAM address, registered
- ram_we  out  1  RAM write enable, registered; write data is the CPU dbo, wired externally
- ram_dout  in  8  RAM read data; synchronous RAM, 1-cycle latency
- vblank  in  1  vertical blank level from video timing
- irq_clr  in  1  one-cycle pulse: CPU write to the IRQ-acknowledge address
- irq_n  out  1  IRQ to CPU, active low
- hold_req  in  1  external master requests the bus
- hold_ack  out  1  CPU is frozen; bus is free

Behaviour:
- Reset (async, rst_n low): cnt=0, cpu_en=0, cpu_rdy=1, cpu_di=0, ram_addr=0, ram_we=0, vid_ack=0, irq_n=1, hold_ack=0, pipeline tags=NONE, vid_pend=0, vblank_d=0. Reset mid-access aborts the access; no ack is issued.
- Divider: cnt counts 0..CE_DIV-1 and wraps. cpu_en is registered high exactly for the cycle where cnt==CE_DIV-1. cpu_en keeps running during hold.
- CPU slot is cycle cnt==0, the first cycle after the wrapper latched a new ab.
  - Granted if cpu_sel && cpu_rdy: register ram_addr=cpu_ab[AW-1:0] and ram_we=~cpu_we_n; push tag CPU.
  - At the CPU slot, video is not granted even if requesting.
- Video grant: on any cycle that is not a granted CPU slot, if vid_req && !vid_pend, then register ram_addr=vid_addr and ram_we=0; push tag VID; set vid_pend.
- Idle: in all other cycles ram_we=0 and ram_addr holds its value.
- Tag pipeline is 2 deep (grant -> RAM sample -> data valid).
  - When a CPU read tag exits, latch cpu_di=ram_dout. This happens at cnt==2 and is stable at cnt==3 for cpu_en.
  - cpu_di holds until the next CPU read completes; a video read never disturbs it.
  - When a VID tag exits, pulse vid_ack and clear vid_pend. Grant-to-ack latency is 2 cycles, or 3 if blocked by a CPU slot.
  - At most one video access is outstanding.
- A CPU write is a single cycle: ram_we high for exactly one cycle (cnt==1 at the RAM).
- IRQ: vblank_d is the registered vblank.
  - A rising edge (vblank && !vblank_d) drives irq_n low.
  - irq_clr drives irq_n high.
  - If both occur in the same cycle, set wins (irq_n=0).
  - While irq_n is low, further edges have no additional effect.
- Hold FSM, states RUN and HOLD:
  - RUN -> HOLD on a cycle with cpu_en && hold_req. In that same clock edge cpu_rdy<=0 and hold_ack<=1; the CPU slot stops being granted from then on.
  - HOLD -> RUN on the first cycle with hold_req low; cpu_rdy<=1 and hold_ack<=0 on that edge.
  - A hold_req pulse that ends before the next cpu_en is ignored.
  - A video access in flight completes normally during HOLD.

Decomposition:
- Shared package: CE_DIV minimum constant; the 2-bit access tag enum (NONE, CPU, VID) and the HOLD FSM state enum, both shared with the bench.
- One natural sub-module: cpu_irq_latch (edge detect + set/clear latch).

Test Plan:
- Reset then free-run with CE_DIV=4 -> cpu_en pulses on cycles 3,7,11...; cpu_rdy=1, irq_n=1.
- CPU read of address 0x0123 (cpu_sel=1) with RAM[0x123]=0x5A -> ram_addr=0x123 at cnt==1, cpu_di=0x5A from cnt==3, ram_we never high.
- vid_req held at vid_addr=0x040, coinciding with a CPU slot doing a write of 0x77 to 0x010 -> ram_we high for one cycle at 0x010; vid_ack 3 cycles after the request with ram_dout=RAM[0x040]; cpu_di unchanged.
- Continuous vid_req with alternating addresses -> one ack every 3 cycles, never two outstanding; a CPU read in between still returns correct data.
- vblank 0->1 -> irq_n=0 the next cycle; irq_clr in the same cycle as a second rising edge -> irq_n stays 0; lone irq_clr -> irq_n=1.
- hold_req raised mid-period -> cpu_rdy=0 and hold_ack=1 on the next cpu_en edge, no CPU grants; drop hold_req -> both restore in 1 cycle. Assert rst_n low while in HOLD -> cpu_rdy=1 and hold_ack=0 immediately.
